// File: rtl/bus_transfer_controller_if.sv
// ---------------------------------------------------------------------------
// bus_transfer_controller_if
// Handshake and bus-enable bundle between the microoperation requesters and
// the bus transfer controller.
//   req        requester -> controller, per-requester level request
//   src_sel    requester -> controller, packed source index per requester
//   dst_sel    requester -> controller, packed destination index per requester
//   grant      controller -> requesters, one-hot current owner
//   ack        controller -> requesters, one-hot completion pulse
//   reg_out    controller -> register fabric, one-hot bus drive enable
//   reg_in     controller -> register fabric, one-hot register load enable
//   busy       controller status, high whenever a transfer is in flight
//   xfer_count controller status, completed transfers modulo 256
// ---------------------------------------------------------------------------
interface bus_transfer_controller_if #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) ();
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*IDX_W-1:0] src_sel;
  logic [NUM_REQ*IDX_W-1:0] dst_sel;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REGS-1:0]      reg_out;
  logic [NUM_REGS-1:0]      reg_in;
  logic                     busy;
  logic [7:0]               xfer_count;

  // Requester / fabric side
  modport master (
    output req, src_sel, dst_sel,
    input  grant, ack, reg_out, reg_in, busy, xfer_count
  );

  // Controller side
  modport slave (
    input  req, src_sel, dst_sel,
    output grant, ack, reg_out, reg_in, busy, xfer_count
  );
endinterface

// File: rtl/bus_transfer_controller.sv
// ---------------------------------------------------------------------------
// bus_transfer_controller
// Round-robin arbiter and sequencer for the shared internal register bus.
// Each granted requester gets one register-to-register move: an ARB cycle
// (grant only), a DRIVE cycle (grant plus Rout[src]/Rin[dst]) and an ACK
// cycle (ack pulse, transfer counted on the edge that ends it).
// Ports:
//   clk    rising-edge system clock
//   clear  asynchronous active-low reset
//   bus    slave side of bus_transfer_controller_if (req/src_sel/dst_sel in,
//          grant/ack/reg_out/reg_in/busy/xfer_count out)
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module bus_transfer_controller #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                       clk,
  input  logic                       clear,
  bus_transfer_controller_if.slave   bus
);

  localparam int WIN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    DRIVE = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [WIN_W-1:0]   ptr_reg, ptr_next;
  logic [WIN_W-1:0]   win_reg, win_next;
  logic [IDX_W-1:0]   src_reg, src_next;
  logic [IDX_W-1:0]   dst_reg, dst_next;
  logic [7:0]         count_reg, count_next;

  logic [IDX_W-1:0]   src_arr [NUM_REQ];
  logic [IDX_W-1:0]   dst_arr [NUM_REQ];
  logic [NUM_REQ-1:0] win_onehot;
  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [WIN_W-1:0]   pick;

  // Unpack per-requester indices and decode the latched winner.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign src_arr[gi]    = bus.src_sel[gi*IDX_W +: IDX_W];
      assign dst_arr[gi]    = bus.dst_sel[gi*IDX_W +: IDX_W];
      assign win_onehot[gi] = (win_reg == WIN_W'(gi));
    end
  endgenerate

  // The requester being acked still holds req this cycle; keep it out of
  // the next arbitration so it cannot win twice for one request.
  assign eligible = bus.req & ((state_reg == ACK) ? ~win_onehot : {NUM_REQ{1'b1}});

  // Round-robin search starting at ptr_reg and wrapping upward.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = WIN_W'(idx);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    win_next   = win_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    count_next = count_reg;

    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = ARB;
        end
      end
      ARB: begin
        state_next = DRIVE;
      end
      DRIVE: begin
        state_next = ACK;
      end
      ACK: begin
        count_next = count_reg + 8'd1;
        state_next = found ? ARB : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Latch the winner and its indices when a new transfer starts, so later
    // changes on src_sel/dst_sel cannot disturb the transfer in flight.
    if ((state_reg == IDLE || state_reg == ACK) && found) begin
      win_next = pick;
      src_next = src_arr[pick];
      dst_next = dst_arr[pick];
      ptr_next = (int'(pick) == NUM_REQ - 1) ? '0 : pick + WIN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      src_reg   <= '0;
      dst_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      win_reg   <= win_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      count_reg <= count_next;
    end
  end

  // Register enables: an index with no matching register simply decodes to
  // no enable, and src==dst naturally asserts both sides of one register.
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign bus.reg_out[gi] = (state_reg == DRIVE) && (src_reg == IDX_W'(gi));
      assign bus.reg_in[gi]  = (state_reg == DRIVE) && (dst_reg == IDX_W'(gi));
    end
  endgenerate

  assign bus.grant      = (state_reg == ARB || state_reg == DRIVE) ? win_onehot : '0;
  assign bus.ack        = (state_reg == ACK) ? win_onehot : '0;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.xfer_count = count_reg;

endmodule

// File: tb/tb_bus_transfer_controller.sv
// ---------------------------------------------------------------------------
// tb_bus_transfer_controller
// Bench for bus_transfer_controller with a small 32-bit register file
// attached to the enables, directed vectors, multi-cycle corner sequences and
// a randomized run checked against a transaction-age reference model.
// ---------------------------------------------------------------------------
module tb_bus_transfer_controller;

  localparam int NR = 4;
  localparam int NG = 16;
  localparam int IW = 4;

  logic clk;
  logic clear;

  bus_transfer_controller_if #(.NUM_REQ(NR), .NUM_REGS(NG), .IDX_W(IW)) bus ();

  bus_transfer_controller #(.NUM_REQ(NR), .NUM_REGS(NG), .IDX_W(IW)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Register file driven by Rout/Rin, as the real datapath would be.
  logic [31:0] rf [NG];
  always @(posedge clk) begin
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < NG; i++) if (bus.reg_out[i]) b = b | rf[i];
    for (int i = 0; i < NG; i++) begin
      if (!clear)          rf[i] <= 32'hA5A50000 | 32'(i * 17);
      else if (bus.reg_in[i]) rf[i] <= b;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---- reference model: one transaction described by its age ----
  // age 0 = nothing in flight; age 1,2 = grant; age 2 = enables; age 3 = ack.
  int         m_age, m_win, m_src, m_dst, m_ptr;
  logic [7:0] m_cnt;
  bit         model_on = 0;

  task automatic model_reset();
    m_age = 0; m_win = 0; m_src = 0; m_dst = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [NR-1:0] r;
    int pick;
    r = bus.req;
    pick = -1;
    if (m_age == 0 || m_age == 3) begin
      if (m_age == 3) m_cnt = m_cnt + 8'd1;
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (pick < 0 && r[i] && !(m_age == 3 && i == m_win)) pick = i;
      end
      if (pick >= 0) begin
        m_win = pick;
        m_src = int'(bus.src_sel[pick*IW +: IW]);
        m_dst = int'(bus.dst_sel[pick*IW +: IW]);
        m_ptr = (pick + 1) % NR;
        m_age = 1;
      end else begin
        m_age = 0;
      end
    end else begin
      m_age++;
    end
  endtask

  function automatic logic [63:0] dut_outs();
    return {15'd0, bus.grant, bus.ack, bus.reg_out, bus.reg_in, bus.busy, bus.xfer_count};
  endfunction

  function automatic logic [63:0] model_outs();
    logic [NR-1:0] g, a;
    logic [NG-1:0] ro, ri;
    g  = (m_age == 1 || m_age == 2) ? NR'(1 << m_win) : '0;
    a  = (m_age == 3) ? NR'(1 << m_win) : '0;
    ro = (m_age == 2 && m_src < NG) ? NG'(1 << m_src) : '0;
    ri = (m_age == 2 && m_dst < NG) ? NG'(1 << m_dst) : '0;
    return {15'd0, g, a, ro, ri, (m_age != 0), m_cnt};
  endfunction

  // One clock: edge, model update on the sampled inputs, then settle.
  task automatic tick();
    @(posedge clk);
    if (model_on) model_edge();
    #1;
  endtask

  task automatic do_reset();
    clear   = 1'b0;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b1;
  endtask

  task automatic set_sel(input int i, input int s, input int d);
    bus.src_sel[i*IW +: IW] = IW'(s);
    bus.dst_sel[i*IW +: IW] = IW'(d);
  endtask

  typedef struct {
    int          r;
    int          src;
    int          dst;
    logic [3:0]  g;
    logic [15:0] ro;
    logic [15:0] ri;
  } vec_t;

  vec_t vt [4];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_cnt;
    logic [31:0] src_val;
    int          ackn, last_ack, busy_low, started, overlap;

    vt[0] = '{1, 3, 7, 4'b0010, 16'h0008, 16'h0080};
    vt[1] = '{0, 5, 5, 4'b0001, 16'h0020, 16'h0020};
    vt[2] = '{3, 0, 15, 4'b1000, 16'h0001, 16'h8000};
    vt[3] = '{2, 15, 0, 4'b0100, 16'h8000, 16'h0001};

    // ---- reset with random requests ----
    clear       = 1'b0;
    bus.req     = 4'($urandom_range(0, 15));
    bus.src_sel = 16'($urandom);
    bus.dst_sel = 16'($urandom);
    #1;
    check("reset_async", dut_outs(), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      bus.req = 4'($urandom_range(0, 15));
      check("reset_hold", dut_outs(), 64'd0);
    end
    clear   = 1'b1;
    bus.req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("idle_after_reset", dut_outs(), 64'd0);
    end

    // ---- table-driven single transfers ----
    exp_cnt = 0;
    foreach (vt[v]) begin
      for (int i = 0; i < NR; i++) set_sel(i, $urandom_range(0, 15), $urandom_range(0, 15));
      set_sel(vt[v].r, vt[v].src, vt[v].dst);
      bus.req = vt[v].g;
      tick();                                      // cycle E+1
      bus.src_sel = ~bus.src_sel;                  // latched indices must hold
      bus.dst_sel = ~bus.dst_sel;
      check($sformatf("v%0d_arb_grant", v), 64'(bus.grant), 64'(vt[v].g));
      check($sformatf("v%0d_arb_en", v), {bus.reg_out, bus.reg_in, bus.ack}, 64'd0);
      tick();                                      // cycle E+2
      src_val = rf[vt[v].src];
      check($sformatf("v%0d_drv_grant", v), 64'(bus.grant), 64'(vt[v].g));
      check($sformatf("v%0d_drv_rout", v), 64'(bus.reg_out), 64'(vt[v].ro));
      check($sformatf("v%0d_drv_rin", v), 64'(bus.reg_in), 64'(vt[v].ri));
      tick();                                      // cycle E+3
      check($sformatf("v%0d_ack", v), 64'(bus.ack), 64'(vt[v].g));
      check($sformatf("v%0d_ack_quiet", v), {bus.grant, bus.reg_out, bus.reg_in}, 64'd0);
      check($sformatf("v%0d_rf_dst", v), 64'(rf[vt[v].dst]), 64'(src_val));
      bus.req = '0;
      tick();
      exp_cnt++;
      check($sformatf("v%0d_count", v), 64'(bus.xfer_count), 64'(exp_cnt));
      check($sformatf("v%0d_idle", v), 64'(bus.busy), 64'd0);
    end

    // ---- round robin with all requesters ----
    do_reset();
    bus.req = 4'b1111;
    ackn = 0; last_ack = -1; busy_low = 0; started = 0;
    for (int c = 0; c < 60 && ackn < 8; c++) begin
      tick();
      if (bus.busy) started = 1;
      else if (started) busy_low++;
      if (bus.ack != 0) begin
        check($sformatf("rr_order%0d", ackn), 64'(bus.ack), 64'(4'b0001 << (ackn % 4)));
        if (last_ack >= 0) check($sformatf("rr_gap%0d", ackn), 64'(c - last_ack), 64'd3);
        last_ack = c;
        ackn++;
      end
      bus.req = 4'b1111 & ~bus.ack;
    end
    check("rr_acks", 64'(ackn), 64'd8);
    check("rr_busy_gaps", 64'(busy_low), 64'd0);

    // ---- ack masking with one permanent requester ----
    do_reset();
    bus.req = 4'b0100;
    ackn = 0; last_ack = -1; overlap = 0;
    for (int c = 0; c < 40 && ackn < 4; c++) begin
      tick();
      if ((bus.grant != 0 && bus.ack != 0) || (bus.grant & (bus.grant - 4'd1)) != 0) overlap++;
      if (bus.ack != 0) begin
        check($sformatf("mask_ack%0d", ackn), 64'(bus.ack), 64'(4'b0100));
        if (last_ack >= 0) check($sformatf("mask_gap%0d", ackn), 64'(c - last_ack), 64'd4);
        last_ack = c;
        ackn++;
      end
    end
    check("mask_acks", 64'(ackn), 64'd4);
    check("mask_overlap", 64'(overlap), 64'd0);

    // ---- reset in the middle of DRIVE ----
    do_reset();
    set_sel(0, 1, 2);
    bus.req = 4'b0001;
    tick();
    tick();
    check("mid_drive_rin", 64'(bus.reg_in), 64'(16'h0004));
    clear = 1'b0;
    #1;
    check("mid_reset_drop", dut_outs(), 64'd0);
    ackn = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.ack != 0) ackn++;
    end
    check("mid_reset_noack", 64'(ackn), 64'd0);
    check("mid_reset_count", 64'(bus.xfer_count), 64'd0);
    clear = 1'b1;
    tick();
    check("resume_grant", 64'(bus.grant), 64'(4'b0001));
    tick();
    check("resume_rin", 64'(bus.reg_in), 64'(16'h0004));
    tick();
    check("resume_ack", 64'(bus.ack), 64'(4'b0001));
    bus.req = '0;
    tick();
    check("resume_count", 64'(bus.xfer_count), 64'd1);

    // ---- 256 transfers wrap the counter ----
    do_reset();
    bus.req = 4'b1111;
    ackn = 0;
    for (int c = 0; c < 1000 && ackn < 256; c++) begin
      tick();
      if (bus.ack != 0) begin
        ackn++;
        if (ackn == 255) check("wrap_pre", 64'(bus.xfer_count), 64'd254);
      end
    end
    bus.req = '0;
    tick();
    check("wrap_acks", 64'(ackn), 64'd256);
    check("wrap_count", 64'(bus.xfer_count), 64'd0);

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    model_on = 1;
    for (int c = 0; c < 1500; c++) begin
      bus.req     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.src_sel = 16'($urandom);
      bus.dst_sel = 16'($urandom);
      tick();
      check($sformatf("rand_c%0d", c), dut_outs(), model_outs());
    end
    model_on = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
